// File: rtl/reg_file_wb_unit_pkg.sv
// Shared encodings for the register-file writeback unit: writeback source,
// load size and FSM state, plus the load alignment rule.
package reg_file_wb_unit_pkg;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2,
    WB_LINK = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_B   = 2'd0,
    LD_H   = 2'd1,
    LD_W   = 2'd2,
    LD_RSV = 2'd3
  } ld_size_e;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } wb_state_e;

  // Reserved size 3 behaves as a word access.
  function automatic logic ld_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      LD_B:    mis = 1'b0;
      LD_H:    mis = addr_lo[0];
      default: mis = (addr_lo != 2'd0);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/reg_file_wb_unit_load_extract.sv
// Big-endian lane select and sign/zero extension of a returned load word,
// plus misalignment detection. Purely combinational.
module reg_file_wb_unit_load_extract
  import reg_file_wb_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     rdata,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  lane_b_s;
  logic [15:0] lane_h_s;

  // Byte 0 sits in the most significant lane of the word.
  always_comb begin
    case (addr_lo)
      2'd0:    lane_b_s = rdata[31:24];
      2'd1:    lane_b_s = rdata[23:16];
      2'd2:    lane_b_s = rdata[15:8];
      2'd3:    lane_b_s = rdata[7:0];
      default: lane_b_s = rdata[31:24];
    endcase
    if (addr_lo[1]) begin
      lane_h_s = rdata[15:0];
    end else begin
      lane_h_s = rdata[31:16];
    end
  end

  // Size selection and extension to the datapath width.
  always_comb begin
    case (size)
      LD_B: begin
        if (is_unsigned) begin
          data = XLEN'(lane_b_s);
        end else begin
          data = XLEN'($signed(lane_b_s));
        end
      end
      LD_H: begin
        if (is_unsigned) begin
          data = XLEN'(lane_h_s);
        end else begin
          data = XLEN'($signed(lane_h_s));
        end
      end
      default: begin
        if (is_unsigned) begin
          data = XLEN'(rdata);
        end else begin
          data = XLEN'($signed(rdata));
        end
      end
    endcase
    misalign = ld_misaligned(size, addr_lo);
  end

endmodule

// File: rtl/reg_file_wb_unit.sv
// Register-file writeback unit: picks ALU, load or link data for one retiring
// instruction per cycle, stalls on outstanding loads, drives the write port.
module reg_file_wb_unit
  import reg_file_wb_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int LINK_OFF = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sel,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_unsigned,
  input  logic [1:0]        in_addr_lo,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              byp_valid,
  output logic [REG_AW-1:0] byp_rd,
  output logic [XLEN-1:0]   byp_data,
  output logic              busy,
  output logic              misalign_err
);

  wb_state_e         state_q, state_d;
  logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
  logic [1:0]        pend_size_q, pend_size_d;
  logic              pend_uns_q, pend_uns_d;
  logic [1:0]        pend_addr_q, pend_addr_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic              misalign_q, misalign_d;

  logic [1:0]        ext_size_s;
  logic              ext_uns_s;
  logic [1:0]        ext_addr_s;
  logic [XLEN-1:0]   ext_data_s;
  logic              ext_mis_s;
  logic [XLEN-1:0]   link_s;

  logic              cmp_s;
  logic              cmp_mis_s;
  logic [REG_AW-1:0] cmp_rd_s;
  logic [XLEN-1:0]   cmp_data_s;

  // While stalled the extractor must see the latched load attributes.
  always_comb begin
    if (state_q == S_WAIT) begin
      ext_size_s = pend_size_q;
      ext_uns_s  = pend_uns_q;
      ext_addr_s = pend_addr_q;
    end else begin
      ext_size_s = in_ld_size;
      ext_uns_s  = in_ld_unsigned;
      ext_addr_s = in_addr_lo;
    end
  end

  reg_file_wb_unit_load_extract #(
    .XLEN(XLEN)
  ) u_load_extract (
    .rdata       (mem_rdata),
    .size        (ext_size_s),
    .is_unsigned (ext_uns_s),
    .addr_lo     (ext_addr_s),
    .data        (ext_data_s),
    .misalign    (ext_mis_s)
  );

  assign link_s = in_pc + XLEN'(LINK_OFF);

  // Next-state logic: decide whether an operation completes this cycle.
  always_comb begin
    state_d     = state_q;
    pend_rd_d   = pend_rd_q;
    pend_size_d = pend_size_q;
    pend_uns_d  = pend_uns_q;
    pend_addr_d = pend_addr_q;
    cmp_s       = 1'b0;
    cmp_mis_s   = 1'b0;
    cmp_rd_s    = in_rd;
    cmp_data_s  = in_alu_result;
    case (state_q)
      S_RUN: begin
        if (in_valid) begin
          case (in_sel)
            WB_ALU: begin
              cmp_s = 1'b1;
            end
            WB_LINK: begin
              cmp_s      = 1'b1;
              cmp_data_s = link_s;
            end
            WB_MEM: begin
              if (mem_rvalid) begin
                cmp_s      = 1'b1;
                cmp_data_s = ext_data_s;
                cmp_mis_s  = ext_mis_s;
              end else begin
                pend_rd_d   = in_rd;
                pend_size_d = in_ld_size;
                pend_uns_d  = in_ld_unsigned;
                pend_addr_d = in_addr_lo;
                state_d     = S_WAIT;
              end
            end
            default: begin
              cmp_s = 1'b0;
            end
          endcase
        end else begin
          cmp_s = 1'b0;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          cmp_s      = 1'b1;
          cmp_rd_s   = pend_rd_q;
          cmp_data_s = ext_data_s;
          cmp_mis_s  = ext_mis_s;
          state_d    = S_RUN;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // Write-port values; index 0 and misaligned loads complete without writing.
  always_comb begin
    rf_we_d    = cmp_s & ~cmp_mis_s & (cmp_rd_s != {REG_AW{1'b0}});
    misalign_d = cmp_s & cmp_mis_s;
    if (rf_we_d) begin
      rf_waddr_d = cmp_rd_s;
      rf_wdata_d = cmp_data_s;
    end else begin
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
    end
  end

  // FSM, pending-load latch and registered write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_RUN;
      pend_rd_q   <= {REG_AW{1'b0}};
      pend_size_q <= 2'd0;
      pend_uns_q  <= 1'b0;
      pend_addr_q <= 2'd0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= {REG_AW{1'b0}};
      rf_wdata_q  <= {XLEN{1'b0}};
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_rd_q   <= pend_rd_d;
      pend_size_q <= pend_size_d;
      pend_uns_q  <= pend_uns_d;
      pend_addr_q <= pend_addr_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      misalign_q  <= misalign_d;
    end
  end

  assign in_ready     = (state_q == S_RUN);
  assign busy         = (state_q == S_WAIT);
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign misalign_err = misalign_q;
  assign byp_valid    = rf_we_q;
  assign byp_rd       = rf_waddr_q;
  assign byp_data     = rf_wdata_q;

endmodule
